// File: rtl/osnt_input_arb_pkg.sv
// Shared definitions for the four-port input arbiter: queue count, arbiter
// state encoding and the packing width of one FIFO entry.
package osnt_input_arb_pkg;

   localparam int NUM_QUEUES = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      WR_PKT = 1'b1
   } state_t;

   // One FIFO entry carries {tlast, tuser, tstrb, tdata}.
   function automatic int fifo_entry_width(input int data_w, input int tuser_w);
      return 1 + tuser_w + data_w / 8 + data_w;
   endfunction

endpackage

// File: rtl/osnt_input_arb_if.sv
// AXI4-Stream bundle used for the master port and each slave port of the
// input arbiter.
interface osnt_input_arb_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int TUSER_WIDTH = 128
) ();

   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic [TUSER_WIDTH-1:0]  tuser;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;

   modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/fallthrough_small_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on dout in the
// cycle after it is written. Writes when full and reads when empty are
// ignored. nearly_full asserts once only one free slot remains.
module fallthrough_small_fifo #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             nearly_full,
   output logic             empty
);

   localparam int DEPTH = 1 << MAX_DEPTH_BITS;
   localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE   = 1;
   localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE   = 1;
   localparam logic [MAX_DEPTH_BITS:0]   CNT_FULL  = DEPTH;
   localparam logic [MAX_DEPTH_BITS:0]   CNT_NEAR  = DEPTH - 1;

   logic [WIDTH-1:0]          mem [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr;
   logic [MAX_DEPTH_BITS:0]   count;
   logic                      do_wr;
   logic                      do_rd;

   assign do_wr       = wr_en && !full;
   assign do_rd       = rd_en && !empty;
   assign full        = (count == CNT_FULL);
   assign nearly_full = (count >= CNT_NEAR);
   assign empty       = (count == '0);
   assign dout        = mem[rd_ptr];

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy; a simultaneous read and write leaves count as is.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/osnt_input_arb.sv
// Four-port AXI4-Stream input arbiter. Each slave port feeds its own FIFO;
// a round-robin pointer moves whole packets, one at a time, onto m_axis.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | at a packet boundary; skip an empty queue, or send its first word
// WR_PKT | mid-packet on cur_queue; pointer frozen until the tlast word leaves
module osnt_input_arb
   import osnt_input_arb_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 64,
   parameter int C_S_AXIS_DATA_WIDTH  = 64,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int FIFO_DEPTH_BITS      = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   osnt_input_arb_if.master        m_axis,
   osnt_input_arb_if.slave         s_axis_0,
   osnt_input_arb_if.slave         s_axis_1,
   osnt_input_arb_if.slave         s_axis_2,
   osnt_input_arb_if.slave         s_axis_3
);

   localparam int DW      = C_S_AXIS_DATA_WIDTH;
   localparam int SW      = DW / 8;
   localparam int UW      = C_S_AXIS_TUSER_WIDTH;
   localparam int ENTRY_W = fifo_entry_width(DW, UW);

   logic [ENTRY_W-1:0]    fifo_din  [NUM_QUEUES];
   logic [ENTRY_W-1:0]    fifo_dout [NUM_QUEUES];
   logic [NUM_QUEUES-1:0] s_valid;
   logic [NUM_QUEUES-1:0] s_ready;
   logic [NUM_QUEUES-1:0] wr_en;
   logic [NUM_QUEUES-1:0] rd_en;
   logic [NUM_QUEUES-1:0] empty;
   logic [NUM_QUEUES-1:0] full;
   logic [NUM_QUEUES-1:0] nearly_full;

   state_t             state;
   state_t             state_nxt;
   logic [1:0]         cur_queue;
   logic [1:0]         cur_queue_nxt;
   logic [ENTRY_W-1:0] head;
   logic               head_last;
   logic               out_valid;
   logic               handshake;

   assign fifo_din[0] = {s_axis_0.tlast, s_axis_0.tuser, s_axis_0.tstrb, s_axis_0.tdata};
   assign fifo_din[1] = {s_axis_1.tlast, s_axis_1.tuser, s_axis_1.tstrb, s_axis_1.tdata};
   assign fifo_din[2] = {s_axis_2.tlast, s_axis_2.tuser, s_axis_2.tstrb, s_axis_2.tdata};
   assign fifo_din[3] = {s_axis_3.tlast, s_axis_3.tuser, s_axis_3.tstrb, s_axis_3.tdata};

   assign s_valid = {s_axis_3.tvalid, s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};

   assign s_axis_0.tready = s_ready[0];
   assign s_axis_1.tready = s_ready[1];
   assign s_axis_2.tready = s_ready[2];
   assign s_axis_3.tready = s_ready[3];

   // Ready drops with one slot still free so a word already in flight on the
   // deasserting edge always has room.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
         assign s_ready[gi] = !reset && !nearly_full[gi];
         assign wr_en[gi]   = s_valid[gi] && s_ready[gi] && !full[gi];

         fallthrough_small_fifo #(
            .WIDTH          (ENTRY_W),
            .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
         ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .din         (fifo_din[gi]),
            .wr_en       (wr_en[gi]),
            .rd_en       (rd_en[gi]),
            .dout        (fifo_dout[gi]),
            .full        (full[gi]),
            .nearly_full (nearly_full[gi]),
            .empty       (empty[gi])
         );
      end
   endgenerate

   assign head      = fifo_dout[cur_queue];
   assign head_last = head[ENTRY_W-1];
   assign out_valid = !reset && !empty[cur_queue];
   assign handshake = out_valid && m_axis.tready;

   assign m_axis.tvalid = out_valid;
   assign m_axis.tlast  = out_valid && head_last;
   assign m_axis.tdata  = head[C_M_AXIS_DATA_WIDTH-1:0];
   assign m_axis.tstrb  = head[DW +: SW];
   assign m_axis.tuser  = head[DW+SW +: C_M_AXIS_TUSER_WIDTH];

   // Arbiter state and round-robin pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cur_queue <= 2'd0;
      end else begin
         state     <= state_nxt;
         cur_queue <= cur_queue_nxt;
      end
   end

   // Next-state, pointer advance and FIFO read strobes.
   always_comb begin
      state_nxt     = state;
      cur_queue_nxt = cur_queue;
      rd_en         = '0;
      rd_en[cur_queue] = handshake;
      case (state)
         IDLE: begin
            if (empty[cur_queue]) begin
               cur_queue_nxt = cur_queue + 2'd1;
            end else if (handshake) begin
               if (head_last) begin
                  cur_queue_nxt = cur_queue + 2'd1;
               end else begin
                  state_nxt = WR_PKT;
               end
            end
         end
         WR_PKT: begin
            if (handshake && head_last) begin
               cur_queue_nxt = cur_queue + 2'd1;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_osnt_input_arb.sv
// Directed bench for osnt_input_arb with a scoreboard: expected words are
// queued when stimulus is issued and a monitor pops/compares each output beat.
module tb_osnt_input_arb;

   localparam int DW   = 64;
   localparam int UW   = 128;
   localparam int SW   = DW / 8;
   localparam int PLEN = 34;

   typedef struct packed {
      logic          last;
      logic [UW-1:0] user;
      logic [SW-1:0] strb;
      logic [DW-1:0] data;
   } beat_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [DW-1:0] s_tdata  [4];
   logic [SW-1:0] s_tstrb  [4];
   logic [UW-1:0] s_tuser  [4];
   logic          s_tvalid [4];
   logic          s_tlast  [4];
   wire           s_tready [4];
   logic          m_tready;
   logic          abort;
   int            accepted [4];

   beat_t exp_q[$];
   int    applied     = 0;
   int    miscompares = 0;

   osnt_input_arb_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();
   osnt_input_arb_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if0 ();
   osnt_input_arb_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if1 ();
   osnt_input_arb_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if2 ();
   osnt_input_arb_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if3 ();

   assign m_if.tready = m_tready;

   assign s_if0.tdata = s_tdata[0]; assign s_if0.tstrb = s_tstrb[0];
   assign s_if0.tuser = s_tuser[0]; assign s_if0.tvalid = s_tvalid[0];
   assign s_if0.tlast = s_tlast[0]; assign s_tready[0] = s_if0.tready;
   assign s_if1.tdata = s_tdata[1]; assign s_if1.tstrb = s_tstrb[1];
   assign s_if1.tuser = s_tuser[1]; assign s_if1.tvalid = s_tvalid[1];
   assign s_if1.tlast = s_tlast[1]; assign s_tready[1] = s_if1.tready;
   assign s_if2.tdata = s_tdata[2]; assign s_if2.tstrb = s_tstrb[2];
   assign s_if2.tuser = s_tuser[2]; assign s_if2.tvalid = s_tvalid[2];
   assign s_if2.tlast = s_tlast[2]; assign s_tready[2] = s_if2.tready;
   assign s_if3.tdata = s_tdata[3]; assign s_if3.tstrb = s_tstrb[3];
   assign s_if3.tuser = s_tuser[3]; assign s_if3.tvalid = s_tvalid[3];
   assign s_if3.tlast = s_tlast[3]; assign s_tready[3] = s_if3.tready;

   osnt_input_arb #(
      .C_M_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_M_AXIS_TUSER_WIDTH (UW),
      .C_S_AXIS_TUSER_WIDTH (UW),
      .FIFO_DEPTH_BITS      (5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .m_axis   (m_if),
      .s_axis_0 (s_if0),
      .s_axis_1 (s_if1),
      .s_axis_2 (s_if2),
      .s_axis_3 (s_if3)
   );

   // Word k of the reference packet: two header words, then {8{k-2}}.
   function automatic beat_t pkt_word(input int k, input logic [UW-1:0] user);
      beat_t      b;
      logic [7:0] c;
      c      = 8'(k - 2);
      b.user = user;
      b.strb = 8'hFF;
      b.last = (k == PLEN - 1);
      if (k == 0)      b.data = 64'hEFBEFECAFECAFECA;
      else if (k == 1) b.data = 64'h00000008EFBEEFBE;
      else             b.data = {8{c}};
      return b;
   endfunction

   task automatic push_pkt(input logic [UW-1:0] user);
      for (int k = 0; k < PLEN; k++) exp_q.push_back(pkt_word(k, user));
   endtask

   task automatic drive_pkt(input int p, input logic [UW-1:0] user);
      beat_t b;
      logic  ok;
      for (int k = 0; k < PLEN; k++) begin
         b = pkt_word(k, user);
         s_tdata[p]  = b.data;
         s_tstrb[p]  = b.strb;
         s_tuser[p]  = b.user;
         s_tlast[p]  = b.last;
         s_tvalid[p] = 1'b1;
         ok = 1'b0;
         while (!ok && !abort) begin
            @(negedge clk);
            ok = s_tready[p];
            @(posedge clk);
            #1;
         end
         if (abort) break;
         accepted[p]++;
      end
      s_tvalid[p] = 1'b0;
      s_tlast[p]  = 1'b0;
   endtask

   task automatic drive_two(input int p);
      drive_pkt(p, UW'(32'h100 + p));
      drive_pkt(p, UW'(32'h110 + p));
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      applied++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s actual=%b required=%b", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      applied++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      check_int("drain_words_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Holds reset two cycles, checks reset outputs, then releases and idles
   // three cycles so the next write lands while the pointer sits at queue 0.
   task automatic reset_dut();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check1("rst_m_tvalid", m_if.tvalid, 1'b0);
      check1("rst_m_tlast", m_if.tlast, 1'b0);
      for (int p = 0; p < 4; p++) check1($sformatf("rst_s_tready_%0d", p), s_tready[p], 1'b0);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Monitor: compare each accepted output beat and check AXI hold rule.
   initial begin : monitor
      beat_t act;
      beat_t e;
      beat_t prev;
      logic  prev_stall;
      prev_stall = 1'b0;
      prev       = '0;
      forever begin
         @(negedge clk);
         act = {m_if.tlast, m_if.tuser, m_if.tstrb, m_if.tdata};
         if (!reset && prev_stall && m_if.tvalid) begin
            applied++;
            if (act !== prev) begin
               miscompares++;
               $display("FAIL hold_stable actual=%h required=%h", act, prev);
            end
         end
         if (!reset && m_if.tvalid && m_tready) begin
            applied++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_word actual=%h required=none", act);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  miscompares++;
                  $display("FAIL out_word actual=%h required=%h", act, e);
               end
            end
         end
         prev_stall = !reset && m_if.tvalid && !m_tready;
         prev       = act;
      end
   end

   initial begin : watchdog
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stimulus
      for (int p = 0; p < 4; p++) begin
         s_tdata[p] = '0; s_tstrb[p] = '0; s_tuser[p] = '0;
         s_tvalid[p] = 1'b0; s_tlast[p] = 1'b0; accepted[p] = 0;
      end
      m_tready = 1'b1;
      abort    = 1'b0;
      #1;
      reset_dut();

      // Single packet on each port in turn.
      for (int p = 0; p < 4; p++) begin
         push_pkt(UW'(8'hAA));
         drive_pkt(p, UW'(8'hAA));
         wait_drain(300);
      end

      // Ports 0 and 2 start in the same cycle: port 0 whole, then port 2.
      reset_dut();
      push_pkt(UW'(8'h20));
      push_pkt(UW'(8'h22));
      fork
         drive_pkt(0, UW'(8'h20));
         drive_pkt(2, UW'(8'h22));
      join
      wait_drain(400);

      // All four ports streaming two packets each: order 0,1,2,3,0,1,2,3.
      reset_dut();
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < 4; p++) push_pkt(UW'(32'h100 + 16 * r + p));
      fork
         drive_two(0);
         drive_two(1);
         drive_two(2);
         drive_two(3);
      join
      wait_drain(1000);

      // Backpressure on port 1: ready drops at 31 queued words, then drains.
      m_tready    = 1'b0;
      accepted[1] = 0;
      push_pkt(UW'(8'h11));
      fork
         drive_pkt(1, UW'(8'h11));
         begin
            repeat (40) @(posedge clk);
            #1;
            check_int("bp_accepted_words", accepted[1], 31);
            check1("bp_s_tready_1", s_tready[1], 1'b0);
            check1("bp_m_tvalid", m_if.tvalid, 1'b1);
            m_tready = 1'b1;
         end
      join
      wait_drain(300);

      // Reset in the middle of a port 3 packet.
      push_pkt(UW'(8'h33));
      fork
         drive_pkt(3, UW'(8'h33));
         begin
            repeat (12) @(posedge clk);
            #1;
            abort = 1'b1;
            reset = 1'b1;
            exp_q.delete();
            @(posedge clk);
            #1;
            check1("midrst_m_tvalid", m_if.tvalid, 1'b0);
            for (int p = 0; p < 4; p++) check1($sformatf("midrst_s_tready_%0d", p), s_tready[p], 1'b0);
         end
      join
      abort = 1'b0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check1("post_rst_m_tvalid", m_if.tvalid, 1'b0);
      push_pkt(UW'(8'h55));
      drive_pkt(3, UW'(8'h55));
      wait_drain(300);

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
